// File: rtl/seq_mult_pkg.sv
// seq_mult_pkg: shared definitions for the shift-add multiplier.
//   - state_e      : FSM encoding (2'd3 is illegal and recovers to idle)
//   - DefaultWidth : default operand width
//   - cnt_width()  : iteration counter width for a given operand width
package seq_mult_pkg;

  localparam int unsigned DefaultWidth = 16;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // At least one bit, so that a degenerate width still gives a legal vector.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

  localparam int unsigned DefaultCntWidth = cnt_width(DefaultWidth);

endpackage

// File: rtl/seq_mult_if.sv
// seq_mult_if: request/response bundle between the execute stage and the multiplier.
//   start   : request to multiply (pulse)
//   a, b    : multiplicand / multiplier, sampled on an accepted start
//   busy    : high while iterating
//   done    : single-cycle pulse, product valid
//   product : 2*WIDTH-bit result, held until the next completion
// master = issuing side, slave = multiplier.
interface seq_mult_if
  import seq_mult_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
);

  logic               start;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  modport master (
    output start, a, b,
    input  busy, done, product
  );

  modport slave (
    input  start, a, b,
    output busy, done, product
  );

endinterface

// File: rtl/seq_mult_cla_add.sv
// cla_add: WIDTH-bit adder built from WIDTH/4 chained 4-bit carry-lookahead slices.
//   A, B : addends
//   Cin  : carry into the least significant slice
//   sum  : WIDTH-bit sum
//   Cout : carry out of the most significant slice
// WIDTH must be a multiple of 4.
module cla_add
  import seq_mult_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] sum,
  output logic             Cout
);

  localparam int unsigned NumSlices = WIDTH / 4;

  // Unpacked so each slice boundary is an independent net.
  logic carry [NumSlices+1];

  assign carry[0] = Cin;

  for (genvar s = 0; s < NumSlices; s++) begin : g_slice
    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    assign g = A[4*s +: 4] & B[4*s +: 4];
    assign p = A[4*s +: 4] ^ B[4*s +: 4];

    // All in-slice carries derived straight from the slice carry-in.
    assign c[0] = carry[s];
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);

    assign carry[s+1] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                      | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c[0]);

    assign sum[4*s +: 4] = p ^ c;
  end

  assign Cout = carry[NumSlices];

endmodule

// File: rtl/seq_mult.sv
// seq_mult: multi-cycle unsigned shift-add multiplier (WIDTH iterations per product).
//   clk : system clock, rising edge
//   rst : synchronous active-high reset; discards any in-flight operation
//   bus : seq_mult_if slave (start/a/b in; busy/done/product out)
// Timing: start in cycle 0, busy in cycles 1..WIDTH, done in cycle WIDTH+1.
// A start in the done cycle is accepted back-to-back. All outputs are registered.
module seq_mult
  import seq_mult_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic       clk,
  input  logic       rst,
  seq_mult_if.slave  bus
);

  localparam int unsigned CntW = cnt_width(WIDTH);

  state_e             state_q;
  logic [CntW-1:0]    cnt_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]   acc_hi_q;
  logic [WIDTH-1:0]   acc_lo_q;
  logic [2*WIDTH-1:0] product_q;
  logic               busy_q;
  logic               done_q;

  logic [WIDTH-1:0]   addend;
  logic [WIDTH-1:0]   sum;
  logic               cout;
  logic [2*WIDTH-1:0] shifted;
  logic               last_iter;

  always_comb begin
    addend = acc_lo_q[0] ? mcand_q : '0;
  end

  cla_add #(
    .WIDTH (WIDTH)
  ) u_add (
    .A    (acc_hi_q),
    .B    (addend),
    .Cin  (1'b0),
    .sum  (sum),
    .Cout (cout)
  );

  // {carry, sum, acc_lo} >> 1: the carry-out is absorbed into the acc_hi MSB.
  assign shifted   = {cout, sum, acc_lo_q[WIDTH-1:1]};
  assign last_iter = (cnt_q == CntW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      mcand_q   <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          done_q <= 1'b0;
          if (bus.start) begin
            mcand_q  <= bus.a;
            acc_hi_q <= '0;
            acc_lo_q <= bus.b;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= StRun;
          end else begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        StRun: begin
          // start is deliberately ignored here.
          {acc_hi_q, acc_lo_q} <= shifted;
          cnt_q                <= cnt_q + CntW'(1);
          if (last_iter) begin
            product_q <= shifted;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= StDone;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.product = product_q;

endmodule

// File: tb/tb_seq_mult.sv
// tb_seq_mult: self-checking bench for seq_mult. Reference products come from plain
// integer multiplication; latency and pulse shape are checked against fixed cycle counts.
module tb_seq_mult;

  localparam int unsigned W = 16;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  seq_mult_if #(.WIDTH(W)) bus ();

  seq_mult #(
    .WIDTH (W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Last completed product the DUT should be holding.
  logic [2*W-1:0] exp_prod;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
    longint unsigned p;
    p = longint'(x) * longint'(y);
    return p[2*W-1:0];
  endfunction

  // Called at a negedge: drives start for one cycle, returns at the negedge of cycle 1.
  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y);
    bus.start = 1'b1;
    bus.a     = x;
    bus.b     = y;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Called at the negedge of cycle 1; returns at the negedge of the done cycle.
  // inj > 0 re-asserts start (a=7, b=9) in that RUN cycle.
  task automatic finish_op(input logic [W-1:0] x, input logic [W-1:0] y, input string tag,
                           input int inj);
    int busy_n;
    int done_at;
    busy_n  = 0;
    done_at = 0;
    check({tag, " held product"}, 64'(bus.product), 64'(exp_prod));
    for (int c = 1; c <= 3 * W && done_at == 0; c++) begin
      if (bus.busy) busy_n++;
      if (bus.done) begin
        done_at = c;
        check({tag, " busy with done"}, 64'(bus.busy), 64'd0);
      end
      if (inj > 0) begin
        bus.start = (c == inj);
        bus.a     = 7;
        bus.b     = 9;
      end
      if (done_at == 0) @(negedge clk);
    end
    check({tag, " busy cycles"}, 64'(busy_n), 64'(W));
    check({tag, " done cycle"}, 64'(done_at), 64'(W + 1));
    exp_prod = ref_mul(x, y);
    check({tag, " product"}, 64'(bus.product), 64'(exp_prod));
  endtask

  // Watches n cycles and checks that done never rises.
  task automatic no_done(input string tag, input int n);
    int seen;
    seen = 0;
    repeat (n) begin
      @(negedge clk);
      if (bus.done) seen++;
    end
    check({tag, " spurious done"}, 64'(seen), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] na;
    logic [W-1:0] nb;
    logic [W-1:0] ca;
    logic [W-1:0] cb;

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    exp_prod  = '0;
    repeat (3) @(negedge clk);
    check("reset busy", 64'(bus.busy), 64'd0);
    check("reset done", 64'(bus.done), 64'd0);
    check("reset product", 64'(bus.product), 64'd0);

    // rst and start together: rst wins, no operation starts.
    bus.start = 1'b1;
    bus.a     = 16'd5;
    bus.b     = 16'd5;
    @(negedge clk);
    rst       = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    check("rst+start busy", 64'(bus.busy), 64'd0);
    no_done("rst+start", W + 4);

    // Basic 3*5.
    issue(16'd3, 16'd5);
    finish_op(16'd3, 16'd5, "3x5", 0);
    @(negedge clk);
    check("3x5 done width", 64'(bus.done), 64'd0);
    check("3x5 idle busy", 64'(bus.busy), 64'd0);

    // Carry-out on every iteration.
    issue(16'hFFFF, 16'hFFFF);
    finish_op(16'hFFFF, 16'hFFFF, "ffff^2", 0);
    check("ffff^2 const", 64'(bus.product), 64'h0000_0000_FFFE_0001);
    @(negedge clk);

    // Zero operands.
    issue(16'h1234, 16'h0000);
    finish_op(16'h1234, 16'h0000, "b=0", 0);
    @(negedge clk);
    issue(16'h0000, 16'hBEEF);
    finish_op(16'h0000, 16'hBEEF, "a=0", 0);
    @(negedge clk);

    // start during RUN is ignored.
    issue(16'd2, 16'd4);
    finish_op(16'd2, 16'd4, "ignore", 5);
    no_done("ignore", 2 * W);
    check("ignore product kept", 64'(bus.product), 64'd8);

    // Reset in cycle 8 of RUN.
    issue(16'd50, 16'd60);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst      = 1'b0;
    exp_prod = '0;
    check("midrst busy", 64'(bus.busy), 64'd0);
    check("midrst product", 64'(bus.product), 64'd0);
    no_done("midrst", 2 * W);
    issue(16'd10, 16'd10);
    finish_op(16'd10, 16'd10, "10x10", 0);
    @(negedge clk);

    // Back-to-back issue from the done cycle.
    issue(16'd6, 16'd7);
    finish_op(16'd6, 16'd7, "6x7", 0);
    issue(16'd100, 16'd200);
    check("b2b busy rises", 64'(bus.busy), 64'd1);
    finish_op(16'd100, 16'd200, "100x200", 0);
    @(negedge clk);

    // Random operations, mixing idle gaps and back-to-back issue.
    na = 16'($urandom);
    nb = 16'($urandom);
    issue(na, nb);
    for (int i = 0; i < 12; i++) begin
      ca = na;
      cb = nb;
      finish_op(ca, cb, "rand", 0);
      na = 16'($urandom);
      nb = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      if (i < 11) begin
        if ($urandom_range(0, 1) == 1) begin
          issue(na, nb);
        end else begin
          @(negedge clk);
          check("rand done width", 64'(bus.done), 64'd0);
          repeat ($urandom_range(0, 3)) @(negedge clk);
          issue(na, nb);
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
